// File: rtl/mtsp_mem_arb_pkg.sv
// Shared types for the MTSP memory arbiter: request payload and scheduler state.
// The payload widths below are the build-wide memory-port widths; module parameters default to them.
package mtsp_mem_arb_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_SRC_W  = 6;
  localparam int MEM_DATA_W = 256;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_SRC_W-1:0]  src;
    logic [MEM_DATA_W-1:0] data;
  } mem_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mtsp_rr_picker.sv
// Combinational round-robin picker: first set bit of valid at or after ptr, wrapping modulo NREQ.
module mtsp_rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  int          idx;
  logic [IDW-1:0] idx_w;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(ptr) + k) % NREQ;
      idx_w = IDW'(idx);
      if (!any && valid[idx_w]) begin
        any             = 1'b1;
        grant_idx       = idx_w;
        grant_oh[idx_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mtsp_mem_arbiter.sv
// Round-robin arbiter sharing one memory request port between NREQ cores, 1-entry buffer each.
// Optional MTSP_MEM_ARB_STAT_EN adds STAT_WAIT, per-requester saturating wait-cycle counters.
module mtsp_mem_arbiter
  import mtsp_mem_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int SRC_W  = MEM_SRC_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        REQ_nEN,
  input  logic [NREQ-1:0]        REQ_WRITE,
  input  logic [NREQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [NREQ*SRC_W-1:0]  REQ_SRC,
  input  logic [NREQ*DATA_W-1:0] REQ_DATA,
  output logic [NREQ-1:0]        REQ_READY,
  output logic                   M_nEN,
  output logic                   M_WRITE,
  output logic [ADDR_W-1:0]      M_ADDR,
  output logic [SRC_W-1:0]       M_SRC,
  output logic [DATA_W-1:0]      M_DATA,
  output logic [IDW-1:0]         M_ID,
  input  logic                   M_READY,
`ifdef MTSP_MEM_ARB_STAT_EN
  output logic [NREQ*16-1:0]     STAT_WAIT,
`endif
  output arb_state_e             DBG_STATE
);

  // Handshakes: an input transfer happens on an edge where !REQ_nEN[i] && REQ_READY[i];
  // an output transfer happens on an edge where !M_nEN && M_READY. Both sides hold until then.

  mem_req_t         buf_q [NREQ];
  logic [NREQ-1:0]  buf_valid;
  logic [NREQ-1:0]  accept;
  logic [IDW-1:0]   ptr;
  arb_state_e       state;
  mem_req_t         out_q;
  logic [IDW-1:0]   out_id;

  logic [NREQ-1:0]  grant_oh;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic             can_load;
  logic             do_grant;

  mtsp_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .valid     (buf_valid),
    .ptr       (ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign accept   = ~REQ_nEN & ~buf_valid;
  assign can_load = (state == IDLE) || ((state == ISSUE) && M_READY);
  assign do_grant = can_load && grant_any;

  // Accept and grant are disjoint per index: accept needs an empty buffer, grant a full one.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      buf_valid <= '0;
      for (int i = 0; i < NREQ; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) begin
          buf_valid[i] <= 1'b1;
          buf_q[i]     <= '{write: REQ_WRITE[i],
                            addr:  REQ_ADDR[i*ADDR_W +: ADDR_W],
                            src:   REQ_SRC[i*SRC_W +: SRC_W],
                            data:  REQ_DATA[i*DATA_W +: DATA_W]};
        end else if (do_grant && grant_oh[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      ptr    <= '0;
      out_q  <= '0;
      out_id <= '0;
    end else begin
      if (do_grant) begin
        out_q  <= buf_q[grant_idx];
        out_id <= grant_idx;
        ptr    <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        state  <= ISSUE;
      end else if ((state == ISSUE) && M_READY) begin
        state <= IDLE;
      end
    end
  end

  assign REQ_READY = ~buf_valid;
  assign M_nEN     = (state != ISSUE);
  assign M_WRITE   = out_q.write;
  assign M_ADDR    = out_q.addr;
  assign M_SRC     = out_q.src;
  assign M_DATA    = out_q.data;
  assign M_ID      = out_id;
  assign DBG_STATE = state;

`ifdef MTSP_MEM_ARB_STAT_EN
  logic [15:0] stat_q [NREQ];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (buf_valid[i] && !(do_grant && grant_oh[i]) && (stat_q[i] != 16'hFFFF))
          stat_q[i] <= stat_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign STAT_WAIT[g*16 +: 16] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_mtsp_mem_arbiter.sv
// Self-checking bench for mtsp_mem_arbiter: directed round-robin/backpressure/reset tasks
// plus random traffic checked by per-requester expected queues.
module tb_mtsp_mem_arbiter;
  import mtsp_mem_arb_pkg::*;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 32;
  localparam int SRC_W  = 6;
  localparam int DATA_W = 256;
  localparam int IDW    = 2;
  localparam int EW     = 1 + ADDR_W + SRC_W + DATA_W;

  logic                   clk;
  logic                   nrst;
  logic [NREQ-1:0]        req_nen;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*SRC_W-1:0]  req_src;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   m_nen;
  logic                   m_write;
  logic [ADDR_W-1:0]      m_addr;
  logic [SRC_W-1:0]       m_src;
  logic [DATA_W-1:0]      m_data;
  logic [IDW-1:0]         m_id;
  logic                   m_ready;
  arb_state_e             dbg_state;
`ifdef MTSP_MEM_ARB_STAT_EN
  logic [NREQ*16-1:0]     stat_wait;
`endif

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q [NREQ][$];
  logic [EW-1:0] sb_exp;

  mtsp_mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .SRC_W(SRC_W), .DATA_W(DATA_W)) dut (
    .CLK       (clk),
    .nRST      (nrst),
    .REQ_nEN   (req_nen),
    .REQ_WRITE (req_write),
    .REQ_ADDR  (req_addr),
    .REQ_SRC   (req_src),
    .REQ_DATA  (req_data),
    .REQ_READY (req_ready),
    .M_nEN     (m_nen),
    .M_WRITE   (m_write),
    .M_ADDR    (m_addr),
    .M_SRC     (m_src),
    .M_DATA    (m_data),
    .M_ID      (m_id),
    .M_READY   (m_ready),
`ifdef MTSP_MEM_ARB_STAT_EN
    .STAT_WAIT (stat_wait),
`endif
    .DBG_STATE (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_sb();
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += exp_q[i].size();
    return n;
  endfunction

  task automatic apply_reset();
    nrst    = 1'b0;
    req_nen = '1;
    flush_sb();
    tick();
    tick();
    nrst = 1'b1;
  endtask

  // driver
  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic set_req(input int i, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [SRC_W-1:0] s, input logic [DATA_W-1:0] d);
    req_nen[i]                    = 1'b0;
    req_write[i]                  = w;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_src[i*SRC_W +: SRC_W]     = s;
    req_data[i*DATA_W +: DATA_W]  = d;
    exp_q[i].push_back({w, a, s, d});
  endtask

  task automatic set_rand_req(input int i, input logic [ADDR_W-1:0] a);
    set_req(i, 1'($urandom_range(0, 1)), a, SRC_W'($urandom_range(0, 63)), rand_data());
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    req_nen = '1;
    m_ready = 1'b1;
    while ((pending() != 0 || m_nen !== 1'b1) && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (pending() != 0 || m_nen !== 1'b1) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d m_nen=%b required pending=0 m_nen=1", pending(), m_nen);
    end
    flush_sb();
  endtask

  // scoreboard: a transfer completes on the next posedge when valid and ready at the negedge
  always @(negedge clk) begin
    if (nrst && m_nen === 1'b0 && m_ready === 1'b1) begin
      checks++;
      if (exp_q[m_id].size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected id=%0d addr=%h required no output", m_id, m_addr);
      end else begin
        sb_exp = exp_q[m_id].pop_front();
        if ({m_write, m_addr, m_src, m_data} !== sb_exp) begin
          errors++;
          $display("FAIL sb_payload id=%0d got w=%b a=%h s=%h d=%h required w=%b a=%h s=%h d=%h",
                   m_id, m_write, m_addr, m_src, m_data,
                   sb_exp[EW-1], sb_exp[EW-2 -: ADDR_W], sb_exp[DATA_W +: SRC_W], sb_exp[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic test_reset();
    checks++;
    if (m_nen !== 1'b1 || req_ready !== 4'b1111 || m_id !== '0 || m_addr !== '0 ||
        m_write !== 1'b0 || m_src !== '0 || m_data !== '0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state m_nen=%b ready=%b id=%0d addr=%h w=%b st=%0d required 1 1111 0 0 0 IDLE",
               m_nen, req_ready, m_id, m_addr, m_write, dbg_state);
    end
  endtask

  task automatic test_all4();
    logic [NREQ-1:0] exp_ready;
    m_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_rand_req(i, 32'h2000 + ADDR_W'(i));
    tick();
    req_nen = '1;
    for (int k = 0; k < NREQ; k++) begin
      tick();
      exp_ready = NREQ'((1 << (k + 1)) - 1);
      checks++;
      if (m_nen !== 1'b0 || m_id !== IDW'(k) || req_ready !== exp_ready) begin
        errors++;
        $display("FAIL all4_order k=%0d m_nen=%b id=%0d ready=%b required 0 %0d %b",
                 k, m_nen, m_id, req_ready, k, exp_ready);
      end
    end
    tick();
    checks++;
    if (m_nen !== 1'b1) begin
      errors++;
      $display("FAIL all4_idle m_nen=%b required 1", m_nen);
    end
    drain(20);
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    set_req(2, 1'b0, 32'h100, 6'd17, rand_data());
    tick();
    req_nen[2] = 1'b1;
    checks++;
    if (m_nen !== 1'b1 || req_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL single_accept m_nen=%b ready2=%b required 1 0", m_nen, req_ready[2]);
    end
    tick();
    checks++;
    if (m_nen !== 1'b0 || m_addr !== 32'h100 || m_id !== 2'd2 || req_ready[2] !== 1'b1 ||
        dbg_state !== ISSUE) begin
      errors++;
      $display("FAIL single_issue m_nen=%b addr=%h id=%0d ready2=%b required 0 100 2 1",
               m_nen, m_addr, m_id, req_ready[2]);
    end
    tick();
    checks++;
    if (m_nen !== 1'b1) begin
      errors++;
      $display("FAIL single_one_cycle m_nen=%b required 1", m_nen);
    end
    drain(20);
  endtask

  // pointer sits at 3 after the single grant of 2
  task automatic test_wrap();
    m_ready = 1'b1;
    set_rand_req(0, 32'h3000);
    set_rand_req(3, 32'h3003);
    tick();
    req_nen = '1;
    tick();
    checks++;
    if (m_nen !== 1'b0 || m_id !== 2'd3) begin
      errors++;
      $display("FAIL wrap_first m_nen=%b id=%0d required 0 3", m_nen, m_id);
    end
    tick();
    checks++;
    if (m_nen !== 1'b0 || m_id !== 2'd0) begin
      errors++;
      $display("FAIL wrap_second m_nen=%b id=%0d required 0 0", m_nen, m_id);
    end
    drain(20);
    set_rand_req(0, 32'h3100);
    set_rand_req(1, 32'h3101);
    tick();
    req_nen = '1;
    tick();
    checks++;
    if (m_id !== 2'd1) begin
      errors++;
      $display("FAIL wrap_ptr_after id=%0d required 1", m_id);
    end
    tick();
    checks++;
    if (m_id !== 2'd0) begin
      errors++;
      $display("FAIL wrap_ptr_next id=%0d required 0", m_id);
    end
    drain(20);
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] a1, a2;
    a1 = $urandom;
    a2 = $urandom;
    m_ready = 1'b0;
    set_rand_req(1, a1);
    tick();
    req_nen[1] = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (m_nen !== 1'b0 || m_addr !== a1 || m_id !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold c=%0d m_nen=%b addr=%h id=%0d required 0 %h 1", c, m_nen, m_addr, m_id, a1);
      end
      if (c == 0) begin
        checks++;
        if (req_ready[1] !== 1'b1) begin
          errors++;
          $display("FAIL bp_drained ready1=%b required 1", req_ready[1]);
        end
        set_rand_req(1, a2);
      end
      if (c == 1) begin
        checks++;
        if (req_ready[1] !== 1'b0) begin
          errors++;
          $display("FAIL bp_second_held ready1=%b required 0", req_ready[1]);
        end
      end
      if (c < 4) begin
        tick();
        req_nen[1] = 1'b1;
      end
    end
    m_ready = 1'b1;
    tick();
    checks++;
    if (m_nen !== 1'b0 || m_addr !== a2) begin
      errors++;
      $display("FAIL bp_reload m_nen=%b addr=%h required 0 %h", m_nen, m_addr, a2);
    end
    tick();
    checks++;
    if (m_nen !== 1'b1) begin
      errors++;
      $display("FAIL bp_done m_nen=%b required 1", m_nen);
    end
    drain(20);
  endtask

  task automatic test_reset_mid_issue();
    m_ready = 1'b0;
    set_rand_req(2, 32'h4444);
    set_rand_req(3, 32'h4445);
    tick();
    req_nen = '1;
    tick();
    checks++;
    if (m_nen !== 1'b0 || m_id !== 2'd2) begin
      errors++;
      $display("FAIL mid_pre m_nen=%b id=%0d required 0 2", m_nen, m_id);
    end
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (m_nen !== 1'b1 || req_ready !== 4'b1111 || m_id !== '0 || m_addr !== '0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL mid_async m_nen=%b ready=%b id=%0d addr=%h required 1 1111 0 0",
               m_nen, req_ready, m_id, m_addr);
    end
    flush_sb();
    tick();
    nrst    = 1'b1;
    m_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (m_nen !== 1'b1 || req_ready !== 4'b1111) begin
      errors++;
      $display("FAIL mid_no_replay m_nen=%b ready=%b required 1 1111", m_nen, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] === 1'b1 && $urandom_range(0, 1) == 1) set_rand_req(i, $urandom);
        else req_nen[i] = 1'b1;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(100);
  endtask

`ifdef MTSP_MEM_ARB_STAT_EN
  task automatic test_stat();
    apply_reset();
    m_ready = 1'b0;
    set_rand_req(0, 32'h5000);
    tick();
    req_nen = '1;
    tick();
    set_rand_req(3, 32'h5003);
    tick();
    req_nen = '1;
    repeat (10) tick();
    checks++;
    if (stat_wait[3*16 +: 16] !== 16'd10 || stat_wait[0 +: 16] !== 16'd0) begin
      errors++;
      $display("FAIL stat_ten s3=%0d s0=%0d required 10 0", stat_wait[3*16 +: 16], stat_wait[0 +: 16]);
    end
    repeat (70000) tick();
    checks++;
    if (stat_wait[3*16 +: 16] !== 16'hFFFF) begin
      errors++;
      $display("FAIL stat_sat s3=%h required ffff", stat_wait[3*16 +: 16]);
    end
    drain(20);
  endtask
`endif

  initial begin
    nrst      = 1'b0;
    req_nen   = '1;
    req_write = '0;
    req_addr  = '0;
    req_src   = '0;
    req_data  = '0;
    m_ready   = 1'b0;
    #12;
    test_reset();
    tick();
    nrst = 1'b1;
    tick();
    test_all4();
    test_single();
    test_wrap();
    test_backpressure();
    test_reset_mid_issue();
    test_back_to_back();
`ifdef MTSP_MEM_ARB_STAT_EN
    test_stat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
